dmem_ctrl: RTL and testbench

//  Initiator for the single-port synchronous SRAM data memory: accepts CPU load/store

---
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : single-port SRAM data-memory initiator, byte stores via RMW
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl #(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [AW-1:0] DADDR,
  input  logic [3:0]    DBE,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  output logic          DRDY,
  output logic          BUSY,
  output logic          M_CSN,
  output logic          M_WEN,
  output logic [AW-1:0] M_A,
  output logic [31:0]   M_DI,
  input  logic [31:0]   M_DOUT
);

  localparam logic [1:0] C_CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rw;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_cnt;
  logic [31:0] w_merge;
  logic        w_accept;
  logic        w_rd_done;

  assign w_accept  = (r_state == S_IDLE) && DREQ;
  assign w_rd_done = (r_state == S_RWAIT) && (r_cnt == 2'd0);

  // Old word from the SRAM with the enabled bytes replaced by store data
  generate
    for (genvar i = 0; i < 4; i++) begin : g_merge
      assign w_merge[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : M_DOUT[8*i +: 8];
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (DREQ) begin
          if (!DRW)              w_next = S_RD;
          else if (DBE == 4'hF)  w_next = S_WR;
          else if (DBE == 4'h0)  w_next = S_DONE;
          else                   w_next = S_RD;
        end
      end
      S_RD:    w_next = S_RWAIT;
      S_RWAIT: if (r_cnt == 2'd0) w_next = r_rw ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rw    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_cnt   <= 2'd0;
      M_CSN   <= 1'b1;
      M_WEN   <= 1'b1;
      M_A     <= '0;
      M_DI    <= 32'h0;
      DRDATA  <= 32'h0;
      DRDY    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Outputs are decoded from the next state so they line up with it
      M_CSN   <= !((w_next == S_RD) || (w_next == S_WR));
      M_WEN   <= (w_next != S_WR);
      DRDY    <= (w_next == S_DONE);
      BUSY    <= (w_next != S_IDLE);

      if (w_accept) begin
        r_rw    <= DRW;
        r_be    <= DBE;
        r_wdata <= DWDATA;
        M_A     <= DADDR;
        M_DI    <= DWDATA;
      end

      if (r_state == S_RD) begin
        r_cnt <= C_CNT_INIT;
      end else if (r_state == S_RWAIT && !w_rd_done) begin
        r_cnt <= r_cnt - 2'd1;
      end

      if (w_rd_done) begin
        if (r_rw) M_DI   <= w_merge;
        else      DRDATA <= M_DOUT;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// tb_dmem_ctrl : two controllers (RD_LAT 1 and 3) on SRAM models, checked
// against a transaction-level model plus directed literal expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

  localparam int AW   = 10;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          DREQ = 1'b0;
  logic          DRW = 1'b0;
  logic [AW-1:0] DADDR = '0;
  logic [3:0]    DBE = 4'h0;
  logic [31:0]   DWDATA = 32'h0;

  logic [1:0]          drdy, busy, csn, wen;
  logic [1:0][AW-1:0]  ma;
  logic [1:0][31:0]    di, drdata, dout;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_ctrl #(.AW(AW), .RD_LAT(LAT0)) u_dut0 (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DBE(DBE),
    .DWDATA(DWDATA), .DRDATA(drdata[0]), .DRDY(drdy[0]), .BUSY(busy[0]),
    .M_CSN(csn[0]), .M_WEN(wen[0]), .M_A(ma[0]), .M_DI(di[0]), .M_DOUT(dout[0])
  );

  dmem_ctrl #(.AW(AW), .RD_LAT(LAT1)) u_dut1 (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DBE(DBE),
    .DWDATA(DWDATA), .DRDATA(drdata[1]), .DRDY(drdy[1]), .BUSY(busy[1]),
    .M_CSN(csn[1]), .M_WEN(wen[1]), .M_A(ma[1]), .M_DI(di[1]), .M_DOUT(dout[1])
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 7) return 32'hAABBCCDD;
    return 32'h5A5A0000 + 32'(i);
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] be, logic [31:0] nw);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // SRAM environment: whole-word writes, read data valid RD_LAT edges after issue
  logic [31:0] sram [2][1024];
  logic [31:0] pipe [2][4];
  assign dout[0] = pipe[0][LAT0-1];
  assign dout[1] = pipe[1][LAT1-1];

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) sram[k][i] <= init_word(i);
      for (int i = 0; i < 4; i++) pipe[k][i] <= 32'h0;
    end
    forever @(posedge CLK) begin
      for (int k = 0; k < 2; k++) begin
        if (!csn[k] && !wen[k]) sram[k][ma[k]] <= di[k];
        pipe[k][0] <= (!csn[k] && wen[k]) ? sram[k][ma[k]] : $urandom;
        for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
      end
    end
  end

  // Transaction-level model: t = cycles since accept (0 = idle), L = total latency,
  // rc/wc = cycle index of the SRAM read/write access (0 = none)
  int          t [2];
  int          tl [2];
  int          rc [2];
  int          wc [2];
  logic [31:0] ref_mem [2][1024];
  logic [AW-1:0] m_addr [2];
  logic [31:0] m_rdat [2];
  logic [31:0] m_wword [2];
  logic        m_load [2];
  logic [31:0] exp_drdata [2];
  bit          armed = 0;
  bit          just_rst = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(i);
      t[k] = 0; tl[k] = 1; rc[k] = 0; wc[k] = 0; m_addr[k] = '0;
      m_rdat[k] = 32'h0; m_wword[k] = 32'h0; m_load[k] = 1'b0; exp_drdata[k] = 32'h0;
    end
    forever @(posedge CLK) begin
      if (RST) armed = 1;
      just_rst = RST;
      for (int k = 0; k < 2; k++) begin
        // the SRAM write lands at the edge that ends the write cycle, reset or not
        if (t[k] != 0 && wc[k] != 0 && t[k] == wc[k]) ref_mem[k][m_addr[k]] = m_wword[k];
        if (RST) begin
          t[k] = 0;
          exp_drdata[k] = 32'h0;
        end else if (t[k] == 0) begin
          if (DREQ) begin
            m_addr[k] = DADDR;
            m_load[k] = !DRW;
            if (!DRW) begin
              tl[k] = 2 + lat_of(k); rc[k] = 1; wc[k] = 0;
              m_rdat[k] = ref_mem[k][DADDR];
            end else if (DBE == 4'hF) begin
              tl[k] = 2; rc[k] = 0; wc[k] = 1; m_wword[k] = DWDATA;
            end else if (DBE == 4'h0) begin
              tl[k] = 1; rc[k] = 0; wc[k] = 0;
            end else begin
              tl[k] = 3 + lat_of(k); rc[k] = 1; wc[k] = tl[k] - 1;
              m_wword[k] = merge(ref_mem[k][DADDR], DBE, DWDATA);
            end
            t[k] = 1;
          end
        end else if (t[k] == tl[k]) begin
          t[k] = 0;
        end else begin
          t[k]++;
          if (t[k] == tl[k] && m_load[k]) exp_drdata[k] = m_rdat[k];
        end
      end
    end
  end

  // Every-cycle comparison of both controllers against the model
  initial begin
    forever @(negedge CLK) begin
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          logic e_busy, e_drdy, e_acc, e_wr;
          e_busy = (t[k] != 0);
          e_drdy = e_busy && (t[k] == tl[k]);
          e_wr   = e_busy && (wc[k] != 0) && (t[k] == wc[k]);
          e_acc  = e_wr || (e_busy && (rc[k] != 0) && (t[k] == rc[k]));
          chk("busy", k, {31'b0, busy[k]}, {31'b0, e_busy});
          chk("drdy", k, {31'b0, drdy[k]}, {31'b0, e_drdy});
          chk("csn", k, {31'b0, csn[k]}, {31'b0, !e_acc});
          chk("drdata", k, drdata[k], exp_drdata[k]);
          if (e_acc) begin
            chk("wen", k, {31'b0, wen[k]}, {31'b0, !e_wr});
            chk("addr", k, 32'(ma[k]), 32'(m_addr[k]));
          end
          if (e_wr) chk("wdata", k, di[k], m_wword[k]);
          if (just_rst) begin
            chk("rst_wen", k, {31'b0, wen[k]}, 32'd1);
            chk("rst_addr", k, 32'(ma[k]), 32'd0);
            chk("rst_di", k, di[k], 32'd0);
          end
        end
      end
    end
  end

  task automatic run_txn(input logic rw, input logic [AW-1:0] a, input logic [3:0] be,
                         input logic [31:0] d, output int lat0, output int lat1,
                         output int ncs0, output logic [31:0] wdi0);
    bit done_all;
    lat0 = 0; lat1 = 0; ncs0 = 0; wdi0 = 32'h0; done_all = 0;
    @(negedge CLK);
    DRW = rw; DADDR = a; DBE = be; DWDATA = d; DREQ = 1'b1;
    @(negedge CLK);
    DREQ = 1'b0;
    for (int n = 1; n <= 30 && !done_all; n++) begin
      if (n > 1) @(negedge CLK);
      if (drdy[0] && lat0 == 0) lat0 = n;
      if (drdy[1] && lat1 == 0) lat1 = n;
      if (!csn[0]) begin
        ncs0++;
        if (!wen[0]) wdi0 = di[0];
      end
      if (busy == 2'b00) done_all = 1;
    end
    chk("txn_done", 0, {31'b0, done_all}, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int n = 0; n < 20 && !idle; n++) begin
      @(negedge CLK);
      if (busy == 2'b00) idle = 1;
    end
    chk("idle_wait", 0, {31'b0, idle}, 32'd1);
  endtask

  initial begin
    int l0, l1, nc, first1, second1, cnt0, ncs1, bad;
    logic [31:0] wd;
    int addrs [5] = '{5, 7, 9, 32, 1023};

    repeat (3) @(negedge CLK);
    chk("reset_busy", 0, {31'b0, busy[0]}, 32'd0);
    chk("reset_csn", 0, {31'b0, csn[0]}, 32'd1);
    chk("reset_drdata", 0, drdata[0], 32'd0);
    RST = 1'b0;

    // 1: load of a preloaded word
    run_txn(1'b0, 10'h005, 4'h0, 32'h0, l0, l1, nc, wd);
    chk("t1_lat", 0, l0, 3);
    chk("t1_lat", 1, l1, 5);
    chk("t1_access", 0, nc, 1);
    chk("t1_data", 0, drdata[0], 32'hDEADBEEF);

    // 2: full store at the top address, then read it back
    run_txn(1'b1, 10'h3FF, 4'hF, 32'h12345678, l0, l1, nc, wd);
    chk("t2_lat", 0, l0, 2);
    chk("t2_lat", 1, l1, 2);
    chk("t2_access", 0, nc, 1);
    chk("t2_wdata", 0, wd, 32'h12345678);
    run_txn(1'b0, 10'h3FF, 4'h0, 32'h0, l0, l1, nc, wd);
    chk("t2_readback", 0, drdata[0], 32'h12345678);
    chk("t2_readback", 1, drdata[1], 32'h12345678);

    // 3: partial store merges into the existing word
    run_txn(1'b1, 10'h007, 4'b0101, 32'h11223344, l0, l1, nc, wd);
    chk("t3_lat", 0, l0, 4);
    chk("t3_lat", 1, l1, 6);
    chk("t3_access", 0, nc, 2);
    chk("t3_wdata", 0, wd, 32'hAA22CC44);
    chk("t3_sram", 0, sram[0][7], 32'hAA22CC44);
    chk("t3_model", 1, ref_mem[1][7], 32'hAA22CC44);

    // 4: store with no byte enabled never touches the SRAM
    run_txn(1'b1, 10'h009, 4'h0, 32'hFFFFFFFF, l0, l1, nc, wd);
    chk("t4_lat", 0, l0, 1);
    chk("t4_access", 0, nc, 0);
    chk("t4_sram", 0, sram[0][9], 32'h5A5A0009);

    // 5: reset while a partial store waits for read data
    @(negedge CLK);
    DRW = 1'b1; DADDR = 10'h020; DBE = 4'b0011; DWDATA = 32'hCAFEF00D; DREQ = 1'b1;
    @(negedge CLK);
    DREQ = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk("t5_busy", k, {31'b0, busy[k]}, 32'd0);
      chk("t5_csn", k, {31'b0, csn[k]}, 32'd1);
      chk("t5_drdy", k, {31'b0, drdy[k]}, 32'd0);
    end
    RST = 1'b0;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      if (drdy != 2'b00 || csn != 2'b11) bad++;
    end
    chk("t5_quiet", 0, bad, 0);
    chk("t5_sram", 0, sram[0][32], 32'h5A5A0020);
    chk("t5_sram", 1, sram[1][32], 32'h5A5A0020);

    // 6: DREQ held high; accepts only in IDLE after DONE
    first1 = 0; second1 = 0; cnt0 = 0; ncs1 = 0;
    @(negedge CLK);
    DRW = 1'b0; DADDR = 10'h005; DBE = 4'h0; DREQ = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      if (drdy[1]) begin
        if (first1 == 0) first1 = n;
        else if (second1 == 0) second1 = n;
      end
      if (drdy[0]) cnt0++;
      if (!csn[1]) ncs1++;
    end
    DREQ = 1'b0;
    chk("t6_first", 1, first1, 5);
    chk("t6_second", 1, second1, 11);
    chk("t6_access", 1, ncs1, 2);
    chk("t6_pulses", 0, cnt0, 3);
    chk("t6_data", 1, drdata[1], 32'hDEADBEEF);
    wait_idle();

    for (int k = 0; k < 2; k++)
      foreach (addrs[j]) chk("mem_final", k, sram[k][addrs[j]], ref_mem[k][addrs[j]]);
    chk("mem_top", 0, sram[0][1023], 32'h12345678);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
